// File: rtl/ex_divider_pkg.sv
// ex_divider_pkg: shared ALU function codes, divider FSM states and width default.
// Revision 1.0
`default_nettype none

package ex_divider_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_SUB  = 5'h01;
  localparam logic [4:0] ALU_AND  = 5'h02;
  localparam logic [4:0] ALU_OR   = 5'h03;
  localparam logic [4:0] ALU_XOR  = 5'h04;
  localparam logic [4:0] ALU_SLL  = 5'h05;
  localparam logic [4:0] ALU_SRL  = 5'h06;
  localparam logic [4:0] ALU_SRA  = 5'h07;
  localparam logic [4:0] ALU_SLT  = 5'h08;
  localparam logic [4:0] ALU_SLTU = 5'h09;
  localparam logic [4:0] ALU_MUL  = 5'h0A;
  localparam logic [4:0] ALU_DIV  = 5'h0C;
  localparam logic [4:0] ALU_DIVU = 5'h0D;
  localparam logic [4:0] ALU_REM  = 5'h0E;
  localparam logic [4:0] ALU_REMU = 5'h0F;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_func(input logic [4:0] func);
    return (func == ALU_DIV) || (func == ALU_DIVU) ||
           (func == ALU_REM) || (func == ALU_REMU);
  endfunction

  function automatic logic is_rem_func(input logic [4:0] func);
    return (func == ALU_REM) || (func == ALU_REMU);
  endfunction

  function automatic logic is_signed_func(input logic [4:0] func);
    return (func == ALU_DIV) || (func == ALU_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_divider_div_step.sv
// div_step: one restoring radix-2 iteration (shift in dividend bit, trial subtract).
// Revision 1.0
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor always holds, so the top bit of diff is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/ex_divider.sv
// ex_divider: multicycle signed/unsigned divide and remainder unit for the EX stage.
// Revision 1.0
`default_nettype none

module ex_divider
  import ex_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_EX_alu_func,
  input  logic [WIDTH-1:0] ID_EX_opa,
  input  logic [WIDTH-1:0] ID_EX_opb,
  output logic             EX_alu_busy,
  output logic [WIDTH-1:0] EX_div_result,
  output logic             EX_div_valid
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [4:0]       func;
  logic             q_neg;
  logic             r_neg;

  logic             req;
  logic             in_signed;
  logic             in_rem;
  logic             opa_neg;
  logic             opb_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] special_result;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;
  logic [WIDTH-1:0] run_result;

  always_comb begin
    req       = is_div_func(ID_EX_alu_func);
    in_signed = is_signed_func(ID_EX_alu_func);
    in_rem    = is_rem_func(ID_EX_alu_func);
    opa_neg   = in_signed & ID_EX_opa[WIDTH-1];
    opb_neg   = in_signed & ID_EX_opb[WIDTH-1];
    mag_a     = opa_neg ? -ID_EX_opa : ID_EX_opa;
    mag_b     = opb_neg ? -ID_EX_opb : ID_EX_opb;
    div_zero  = (ID_EX_opb == '0);
    overflow  = in_signed && (ID_EX_opa == MIN_NEG) && (ID_EX_opb == '1);
    // Overflow quotient equals the dividend itself (most negative value).
    if (div_zero)
      special_result = in_rem ? ID_EX_opa : '1;
    else
      special_result = in_rem ? '0 : ID_EX_opa;
  end

  assign EX_alu_busy = req && ((state == DIV_IDLE) || (state == DIV_RUN));

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in       (rem),
    .divisor      (dvsr),
    .dividend_bit (quo[WIDTH-1]),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // Final-step outputs feed the result directly so DONE follows the last RUN cycle.
  always_comb begin
    q_final    = {quo[WIDTH-2:0], step_q};
    q_fixed    = q_neg ? -q_final : q_final;
    r_fixed    = r_neg ? -step_rem : step_rem;
    run_result = is_rem_func(func) ? r_fixed : q_fixed;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= DIV_IDLE;
      count         <= '0;
      rem           <= '0;
      quo           <= '0;
      dvsr          <= '0;
      func          <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      EX_div_valid  <= 1'b0;
      EX_div_result <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          EX_div_valid  <= 1'b0;
          EX_div_result <= '0;
          if (req) begin
            func <= ID_EX_alu_func;
            if (div_zero || overflow) begin
              EX_div_valid  <= 1'b1;
              EX_div_result <= special_result;
              state         <= DIV_DONE;
            end else begin
              rem   <= '0;
              quo   <= mag_a;
              dvsr  <= mag_b;
              q_neg <= opa_neg ^ opb_neg;
              r_neg <= opa_neg;
              count <= '0;
              state <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          if (!req) begin
            count <= '0;
            state <= DIV_IDLE;
          end else begin
            rem   <= step_rem;
            quo   <= q_final;
            count <= count + CW'(1);
            if (count == LAST_STEP) begin
              EX_div_valid  <= 1'b1;
              EX_div_result <= run_result;
              count         <= '0;
              state         <= DIV_DONE;
            end
          end
        end
        DIV_DONE: begin
          EX_div_valid  <= 1'b0;
          EX_div_result <= '0;
          state         <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_divider.sv
// tb_ex_divider: directed and randomized checks of ex_divider against an arithmetic reference.
// Revision 1.0
`default_nettype none

module tb_ex_divider;
  import ex_divider_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  func;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic [31:0] result;
  logic        valid;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  int          last_busy;
  int          last_done_cyc;
  logic [31:0] last_result;

  ex_divider #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ID_EX_alu_func (func),
    .ID_EX_opa      (opa),
    .ID_EX_opb      (opb),
    .EX_alu_busy    (busy),
    .EX_div_result  (result),
    .EX_div_valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [4:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    int  sa;
    int  sb;
    logic sgn;
    logic is_r;
    sa   = a;
    sb   = b;
    sgn  = (f == ALU_DIV) || (f == ALU_REM);
    is_r = (f == ALU_REM) || (f == ALU_REMU);
    if (b == 32'd0) return is_r ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_r ? 32'd0 : 32'h8000_0000;
    if (sgn) return is_r ? 32'(sa % sb) : 32'(sa / sb);
    return is_r ? (a % b) : (a / b);
  endfunction

  function automatic int ref_busy(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (f == ALU_DIV) || (f == ALU_REM);
    if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Drive one operation starting at a negedge, count busy cycles, capture the valid result.
  task automatic do_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                       input logic [31:0] b, input bit scramble);
    int n;
    bit early_valid;
    @(negedge clk);
    func = f; opa = a; opb = b;
    #1;
    check({tag, "_idle_valid"}, 32'(valid), 32'd0);
    check({tag, "_idle_result"}, result, 32'd0);
    n = 0;
    early_valid = 1'b0;
    while (busy && n < 100) begin
      if (valid) early_valid = 1'b1;
      n++;
      @(negedge clk);
      if (scramble) begin
        opa = $urandom;
        opb = $urandom;
      end
      #1;
    end
    check({tag, "_timeout"}, 32'(n < 100), 32'd1);
    check({tag, "_early_valid"}, 32'(early_valid), 32'd0);
    last_busy     = n;
    last_done_cyc = cyc;
    last_result   = result;
    check({tag, "_busy"}, n, ref_busy(f, a, b));
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_result"}, result, ref_div(f, a, b));
  endtask

  task automatic idle_cycles(input string tag, input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      func = ALU_ADD;
      #1;
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_valid"}, 32'(valid), 32'd0);
    end
  endtask

  initial begin
    int c1;
    int n;
    bit pulsed;
    logic [4:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b0; func = ALU_ADD; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_state", 32'(dut.state), 32'(DIV_IDLE));
    check("reset_count", 32'(dut.count), 32'd0);
    check("reset_quo", dut.quo, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles("nondiv", 2);

    // Basic directed cases
    do_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_100_7_val", last_result, 32'd14);
    do_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 1'b0);
    check("remu_100_7_val", last_result, 32'd2);
    do_op("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_m7_2_val", last_result, 32'hFFFF_FFFD);
    do_op("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("rem_m7_2_val", last_result, 32'hFFFF_FFFF);
    do_op("rem_7_m2", ALU_REM, 32'd7, 32'hFFFF_FFFE, 1'b0);
    check("rem_7_m2_val", last_result, 32'd1);
    do_op("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 1'b0);
    check("divu_5_0_val", last_result, 32'hFFFF_FFFF);
    do_op("remu_5_0", ALU_REMU, 32'd5, 32'd0, 1'b0);
    check("remu_5_0_val", last_result, 32'd5);
    do_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_val", last_result, 32'h8000_0000);
    do_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("rem_ovf_val", last_result, 32'd0);
    do_op("divu_max", ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0);
    idle_cycles("after_single", 1);

    // Back-to-back divides, then a non-divide keeps busy low
    do_op("b2b_first", ALU_DIV, 32'd100, 32'd7, 1'b0);
    c1 = last_done_cyc;
    do_op("b2b_second", ALU_DIV, 32'd81, 32'd9, 1'b0);
    check("b2b_spacing", last_done_cyc - c1, 32'd34);
    check("b2b_second_val", last_result, 32'd9);
    idle_cycles("b2b_gap", 3);

    // Operands changing during RUN must not disturb the result
    do_op("scramble_div", ALU_DIV, 32'hF000_1234, 32'd37, 1'b1);

    // req drops mid-RUN: abort without a valid pulse
    @(negedge clk);
    func = ALU_DIVU; opa = 32'd1000; opb = 32'd3;
    repeat (6) @(negedge clk);
    func = ALU_ADD;
    @(negedge clk);
    #1;
    check("abort_state", 32'(dut.state), 32'(DIV_IDLE));
    check("abort_valid", 32'(valid), 32'd0);
    idle_cycles("abort_after", 3);

    // Reset at RUN cycle 10
    @(negedge clk);
    func = ALU_DIVU; opa = 32'hDEAD_BEEF; opb = 32'd13;
    repeat (11) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_state", 32'(dut.state), 32'(DIV_IDLE));
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rem", dut.rem, 32'd0);
    func = ALU_ADD;
    pulsed = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (n == 2) rst = 1'b1;
      #1;
      if (valid) pulsed = 1'b1;
      n++;
    end
    check("midrst_no_pulse", 32'(pulsed), 32'd0);
    do_op("post_rst_divu", ALU_DIVU, 32'd9, 32'd3, 1'b0);
    check("post_rst_val", last_result, 32'd3);

    // Randomized operations with biased corner operands
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: rf = ALU_DIV;
        1: rf = ALU_DIVU;
        2: rf = ALU_REM;
        default: rf = ALU_REMU;
      endcase
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -32'($urandom_range(1, 15));
        4: ra = 32'd0;
        default: ;
      endcase
      do_op("rand", rf, ra, rb, i[0]);
    end

    @(negedge clk);
    func = ALU_ADD;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
